trap_pulse_gen: RTL and testbench
=================================

# trap_pulse_gen

Digital trapezoidal pulse generator that produces the per-cycle drive code for the pulse/rect current and voltage sources (delay, rise, high, fall, low; one-shot or periodic). It sits directly upstream of the source stage: its `out` word is the level that the DAC-backed source applies, so the source sees the same waveform shape as the analog `pulse` description (initial value, pulse value, rise, fall, delay, width, period).

## Interface
Parameters:
- `W`, 16: sample width of `iv`, `pv`, `out`.
- `TW`, 24: width of every phase-duration input and its counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin waveform; accepted only in IDLE.
- `stop` in 1: abort to IDLE at the next edge.
- `periodic` in 1: 1 = repeat RISE..LOW forever; 0 = one shot.
- `iv` in W: initial/low level, unsigned code.
- `pv` in W: pulse/high level, unsigned code.
- `td`, `tr`, `th`, `tf`, `tl` in TW each: delay, rise, high, fall and low durations in cycles.
- `rise_step`, `fall_step` in W+8: ramp magnitude per cycle, 8 fractional bits.
- `out` out W: registered drive code.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a one-shot waveform completes.
- `phase` out 3: current state encoding.

## Operation
- States: IDLE, DELAY, RISE, HIGH, FALL, LOW.
- On `start` in IDLE, all inputs are latched into shadow registers. Later input changes are ignored until the next start.
- The next state is the first phase of DELAY, RISE, HIGH, FALL with nonzero length. Each phase lasts exactly its latched length in cycles.
- Zero-length phases are skipped in the same transition. If all of `tr`, `th`, `tf` are zero, the block returns to IDLE and raises `done`; this holds even when `periodic` = 1.
- Sequence: DELAY -> RISE -> HIGH -> FALL. After FALL:
  - one shot: go to IDLE and pulse `done`.
  - periodic: go to LOW, then back to the first nonzero of RISE/HIGH/FALL. DELAY occurs only once.
- Output levels:
  - DELAY, LOW, IDLE: `out` = latched iv.
  - HIGH: `out` = latched pv.
  - RISE cycle k: `out` = iv + k·rise_step, toward pv.
  - FALL cycle k: `out` = pv - k·fall_step, toward iv.
- Ramp arithmetic:
  - The accumulator is W+9 bits signed (integer plus 8 fractional bits); `out` is the truncated integer part.
  - Direction is chosen by comparing pv and iv. If pv < iv, RISE decrements and FALL increments.
  - The accumulator saturates at the target level.
  - The final cycle of RISE is forced to exactly pv, and the final cycle of FALL to exactly iv, whatever the step.
- `stop` in any state: IDLE at the next edge, `out` = latched iv, no `done`. If `start` and `stop` are high together, `stop` wins.
- `start` while busy is ignored.

## Timing
- Reset values: `out` = 0, `busy` = 0, `done` = 0, `phase` = IDLE, shadow registers = 0, phase counter = 0.
- Latency:
  - `start` sampled at edge N: first phase state and its first `out` value are visible after edge N; `busy` rises at N.
  - The last phase cycle ends at edge N + Σ(lengths). Next state and `done` are registered together at that edge.
- Counters run 1..len; TW-bit lengths up to 2^TW − 1 are legal, and the counter never wraps.
- Reset asserted mid-waveform: immediate return to reset values, asynchronous.

## Configuration
- `TRAP_PULSE_GEN_PERIOD_COUNT_EN`:
  - Defined: adds output `periods` (32 bits). It is cleared on `start`, increments on each LOW -> RISE/HIGH/FALL transition, and saturates at 2^32 − 1.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `trap_pulse_pkg` holds:
  - the state enum `tpg_state_t` with fixed encodings IDLE=0 … LOW=5 (these drive `phase`);
  - the fractional-bit constant `TPG_FRAC = 8`.
- Sub-module `tpg_ramp_acc` holds the accumulator: load, signed step, saturate at target, force-to-target on last cycle. The FSM and counters stay in the top module.

## Test plan
- **One shot, rising:** iv=100, pv=1100, td=2, tr=4, th=3, tf=4, rise_step=fall_step=250·256, periodic=0.
  - `out`: 100,100, 350,600,850,1100, 1100×3, 850,600,350,100.
  - Then IDLE, with `done` high for 1 cycle at edge N+13.
- **Periodic:** same values, tl=2, periodic=1, three periods.
  - DELAY appears once; the period is 13 cycles.
  - With the macro defined, `periods` = 2 at the start of the third RISE.
- **Inverted levels and saturation:** iv=1000, pv=0, tr=3, rise_step=500·256.
  - `out` 500, 0 (saturated), 0 (forced); RISE ends on pv.
- **Zero phases:** td=0, tr=0, tf=0, th=5.
  - HIGH for 5 cycles directly after start, then IDLE and `done`.
  - With all of tr/th/tf = 0: `done` at start+1, `busy` high for 1 cycle.
- **Abort and collisions:**
  - `stop` during HIGH -> IDLE next edge, `out`=iv, no `done`.
  - `start` & `stop` together in IDLE -> stays IDLE.
  - `start` while busy -> ignored; changing `pv` mid-run does not alter `out`.
- **Async reset:** `rst_n` low mid-RISE between edges -> `out`=0, `busy`=0 immediately. After release, IDLE until `start`.

Source files
------------

// File: rtl/trap_pulse_gen_pkg.sv
// Shared types for the trapezoidal pulse generator: state enum, fraction width, sequencing helper.
// Latency: none (package only).
// Backpressure: not applicable.
package trap_pulse_pkg;

  // State encodings are visible on the phase output, so they are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    RISE  = 3'd2,
    HIGH  = 3'd3,
    FALL  = 3'd4,
    LOW   = 3'd5
  } tpg_state_t;

  // Fractional bits carried by the ramp steps and the accumulator.
  localparam int TPG_FRAC = 8;

  // First phase of the RISE/HIGH/FALL body that has a nonzero length (IDLE if none).
  function automatic tpg_state_t tpg_first_ramp(input logic tr_nz, input logic th_nz,
                                                input logic tf_nz);
    if (tr_nz)      return RISE;
    else if (th_nz) return HIGH;
    else if (tf_nz) return FALL;
    else            return IDLE;
  endfunction

endpackage

// File: rtl/trap_pulse_gen_ramp_acc.sv
// Ramp accumulator: loads a start level, steps toward a target each cycle, saturates, forces target on last cycle.
// Latency: lvl is the combinational next value; the accumulator register updates on the same edge.
// Backpressure: none; the owner asserts load or adv only on cycles that belong to a ramp.
module tpg_ramp_acc
  import trap_pulse_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         adv,
  input  logic         last,
  input  logic         dn,
  input  logic [W-1:0] base,
  input  logic [W-1:0] tgt,
  input  logic [W+7:0] step,
  output logic [W-1:0] lvl
);

  localparam int AW = W + TPG_FRAC + 1;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] from_v;
  logic signed [AW-1:0] tgt_v;
  logic signed [AW-1:0] step_v;
  logic signed [AW-1:0] gap;

  // Next accumulator value. Saturation is decided by comparing the step against the
  // remaining distance to the target, so the sum itself can never overflow the width.
  always_comb begin
    from_v = load ? $signed({1'b0, base, {TPG_FRAC{1'b0}}}) : acc;
    tgt_v  = $signed({1'b0, tgt, {TPG_FRAC{1'b0}}});
    step_v = $signed({1'b0, step});
    gap    = dn ? (from_v - tgt_v) : (tgt_v - from_v);
    if (last || (step_v >= gap)) begin
      acc_nxt = tgt_v;
    end else if (dn) begin
      acc_nxt = from_v - step_v;
    end else begin
      acc_nxt = from_v + step_v;
    end
  end

  assign lvl = acc_nxt[W+TPG_FRAC-1:TPG_FRAC];

  // Hold the accumulator between ramp cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load || adv) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/trap_pulse_gen.sv
// Trapezoidal pulse generator (delay/rise/high/fall/low, one-shot or periodic); TRAP_PULSE_GEN_PERIOD_COUNT_EN adds a period counter.
// Latency: start sampled at edge N shows the first phase and its level after edge N; each phase lasts its length.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE at the next edge and wins over start.
module trap_pulse_gen
  import trap_pulse_pkg::*;
#(
  parameter int W  = 16,
  parameter int TW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [W-1:0]  iv,
  input  logic [W-1:0]  pv,
  input  logic [TW-1:0] td,
  input  logic [TW-1:0] tr,
  input  logic [TW-1:0] th,
  input  logic [TW-1:0] tf,
  input  logic [TW-1:0] tl,
  input  logic [W+7:0]  rise_step,
  input  logic [W+7:0]  fall_step,
  output logic [W-1:0]  out,
  output logic          busy,
  output logic          done,
  output logic [2:0]    phase
`ifdef TRAP_PULSE_GEN_PERIOD_COUNT_EN
  ,
  output logic [31:0]   periods
`endif
);

  tpg_state_t    state;
  tpg_state_t    nstate;
  tpg_state_t    first_ramp;
  tpg_state_t    after_fall;
  logic [TW-1:0] cnt;
  logic [TW-1:0] ncnt;
  logic [TW-1:0] cur_len;
  logic [TW-1:0] nlen;
  logic          fin;
  logic          enter;
  logic          ndone;
  logic          wrap;
  logic          accept;
  logic          ramps_zero;
  logic          idle;

  // Shadow copies of the waveform description, captured on an accepted start.
  logic [W-1:0]  iv_q, pv_q;
  logic [TW-1:0] td_q, tr_q, th_q, tf_q, tl_q;
  logic [W+7:0]  rs_q, fs_q;
  logic          per_q;

  // Working values: live inputs on the start cycle, shadows while a waveform runs.
  logic [W-1:0]  s_iv, s_pv;
  logic [TW-1:0] s_td, s_tr, s_th, s_tf, s_tl;
  logic [W+7:0]  s_rs, s_fs;
  logic          s_per;

  assign idle  = (state == IDLE);
  assign s_iv  = idle ? iv        : iv_q;
  assign s_pv  = idle ? pv        : pv_q;
  assign s_td  = idle ? td        : td_q;
  assign s_tr  = idle ? tr        : tr_q;
  assign s_th  = idle ? th        : th_q;
  assign s_tf  = idle ? tf        : tf_q;
  assign s_tl  = idle ? tl        : tl_q;
  assign s_rs  = idle ? rise_step : rs_q;
  assign s_fs  = idle ? fall_step : fs_q;
  assign s_per = idle ? periodic  : per_q;

  // Next-state and phase-counter decision. With an empty RISE/HIGH/FALL body the
  // waveform spends a single DELAY cycle at iv and then finishes.
  always_comb begin
    nstate     = state;
    ncnt       = cnt + 1'b1;
    enter      = 1'b0;
    ndone      = 1'b0;
    wrap       = 1'b0;
    accept     = 1'b0;
    ramps_zero = (s_tr == '0) && (s_th == '0) && (s_tf == '0);
    first_ramp = tpg_first_ramp(s_tr != '0, s_th != '0, s_tf != '0);
    if (!s_per)            after_fall = IDLE;
    else if (s_tl != '0)   after_fall = LOW;
    else                   after_fall = first_ramp;

    case (state)
      DELAY:   cur_len = ramps_zero ? {{(TW-1){1'b0}}, 1'b1} : s_td;
      RISE:    cur_len = s_tr;
      HIGH:    cur_len = s_th;
      FALL:    cur_len = s_tf;
      LOW:     cur_len = s_tl;
      default: cur_len = '0;
    endcase
    fin = !idle && (cnt == cur_len);

    if (stop) begin
      nstate = IDLE;
    end else if (idle) begin
      if (start) begin
        accept = 1'b1;
        enter  = 1'b1;
        nstate = ((s_td != '0) || ramps_zero) ? DELAY : first_ramp;
      end
    end else if (fin) begin
      enter = 1'b1;
      case (state)
        DELAY:   nstate = ramps_zero ? IDLE : first_ramp;
        RISE:    nstate = (s_th != '0) ? HIGH : ((s_tf != '0) ? FALL : after_fall);
        HIGH:    nstate = (s_tf != '0) ? FALL : after_fall;
        FALL: begin
          nstate = after_fall;
          wrap   = s_per && (s_tl == '0);
        end
        LOW: begin
          nstate = first_ramp;
          wrap   = 1'b1;
        end
        default: nstate = IDLE;
      endcase
      ndone = (nstate == IDLE);
    end

    if (enter)            ncnt = {{(TW-1){1'b0}}, 1'b1};
    if (nstate == IDLE)   ncnt = '0;

    case (nstate)
      RISE:    nlen = s_tr;
      FALL:    nlen = s_tf;
      default: nlen = '0;
    endcase
  end

  logic         ramp_on;
  logic         in_rise;
  logic [W-1:0] ramp_lvl;

  assign in_rise = (nstate == RISE);
  assign ramp_on = in_rise || (nstate == FALL);

  tpg_ramp_acc #(.W(W)) u_ramp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ramp_on && enter),
    .adv   (ramp_on && !enter),
    .last  (ncnt == nlen),
    .dn    (in_rise ? (s_pv < s_iv) : (s_pv > s_iv)),
    .base  (in_rise ? s_iv : s_pv),
    .tgt   (in_rise ? s_pv : s_iv),
    .step  (in_rise ? s_rs : s_fs),
    .lvl   (ramp_lvl)
  );

  // FSM state, phase counter, shadows and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      phase <= 3'd0;
      iv_q  <= '0;
      pv_q  <= '0;
      td_q  <= '0;
      tr_q  <= '0;
      th_q  <= '0;
      tf_q  <= '0;
      tl_q  <= '0;
      rs_q  <= '0;
      fs_q  <= '0;
      per_q <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      busy  <= (nstate != IDLE);
      done  <= ndone;
      phase <= nstate;
      case (nstate)
        IDLE:       out <= iv_q;
        HIGH:       out <= s_pv;
        RISE, FALL: out <= ramp_lvl;
        default:    out <= s_iv;
      endcase
      if (accept) begin
        iv_q  <= iv;
        pv_q  <= pv;
        td_q  <= td;
        tr_q  <= tr;
        th_q  <= th;
        tf_q  <= tf;
        tl_q  <= tl;
        rs_q  <= rise_step;
        fs_q  <= fall_step;
        per_q <= periodic;
      end
    end
  end

`ifdef TRAP_PULSE_GEN_PERIOD_COUNT_EN
  // Completed-period counter: cleared by an accepted start, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periods <= '0;
    end else if (accept) begin
      periods <= '0;
    end else if (wrap && (periods != 32'hFFFF_FFFF)) begin
      periods <= periods + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trap_pulse_gen.sv
module tb_trap_pulse_gen;

  localparam int W  = 16;
  localparam int TW = 24;
  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_DELAY = 3'd1;
  localparam logic [2:0] P_RISE  = 3'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          periodic = 1'b0;
  logic [W-1:0]  iv = '0;
  logic [W-1:0]  pv = '0;
  logic [TW-1:0] td = '0, tr = '0, th = '0, tf = '0, tl = '0;
  logic [W+7:0]  rise_step = '0, fall_step = '0;
  logic [W-1:0]  out;
  logic          busy, done;
  logic [2:0]    phase;
`ifdef TRAP_PULSE_GEN_PERIOD_COUNT_EN
  logic [31:0]   periods;
`endif

  int vectors = 0;
  int fails = 0;

  // Reference waveform description (what the DUT should have latched).
  int     m_iv, m_pv, m_td, m_tr, m_th, m_tf, m_tl;
  longint m_rs, m_fs;
  bit     m_per;

  typedef struct packed {
    logic [15:0] out;
    logic        busy;
    logic        done;
    logic [2:0]  phase;
    logic [31:0] periods;
  } exp_t;

  trap_pulse_gen #(.W(W), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .iv        (iv),
    .pv        (pv),
    .td        (td),
    .tr        (tr),
    .th        (th),
    .tf        (tf),
    .tl        (tl),
    .rise_step (rise_step),
    .fall_step (fall_step),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .phase     (phase)
`ifdef TRAP_PULSE_GEN_PERIOD_COUNT_EN
    ,
    .periods   (periods)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Level on ramp cycle k of len, going from a toward b with step s (8 fractional bits).
  function automatic int ramp(int a, int b, longint s, int k, int len);
    longint v;
    if (k == len) return b;
    if (b >= a) begin
      v = longint'(a) * 256 + longint'(k) * s;
      if (v > longint'(b) * 256) v = longint'(b) * 256;
    end else begin
      v = longint'(a) * 256 - longint'(k) * s;
      if (v < longint'(b) * 256) v = longint'(b) * 256;
    end
    return int'(v >>> 8);
  endfunction

  // Expected outputs in the i-th cycle after the start edge.
  function automatic exp_t exp_at(int i);
    exp_t e;
    int j, body, per_len;
    e.out = 16'(m_iv); e.busy = 1'b0; e.done = 1'b0; e.phase = 3'd0; e.periods = '0;
    body = m_tr + m_th + m_tf;
    if (body == 0) begin
      if (i == 1) begin e.busy = 1'b1; e.phase = 3'd1; end
      else if (i == 2) e.done = 1'b1;
      return e;
    end
    if (i <= m_td) begin e.busy = 1'b1; e.phase = 3'd1; return e; end
    j = i - m_td;
    if (m_per) begin
      per_len = body + m_tl;
      e.periods = 32'((j - 1) / per_len);
      j = (j - 1) % per_len + 1;
    end else if (j > body) begin
      if (j == body + 1) e.done = 1'b1;
      return e;
    end
    e.busy = 1'b1;
    if (j <= m_tr) begin
      e.phase = 3'd2; e.out = 16'(ramp(m_iv, m_pv, m_rs, j, m_tr));
    end else if (j <= m_tr + m_th) begin
      e.phase = 3'd3; e.out = 16'(m_pv);
    end else if (j <= body) begin
      e.phase = 3'd4; e.out = 16'(ramp(m_pv, m_iv, m_fs, j - m_tr - m_th, m_tf));
    end else begin
      e.phase = 3'd5;
    end
    return e;
  endfunction

  task automatic set_cfg(input int a_iv, input int a_pv, input int a_td, input int a_tr,
                         input int a_th, input int a_tf, input int a_tl,
                         input longint a_rs, input longint a_fs, input bit a_per);
    m_iv = a_iv; m_pv = a_pv; m_td = a_td; m_tr = a_tr; m_th = a_th; m_tf = a_tf;
    m_tl = a_tl; m_rs = a_rs; m_fs = a_fs; m_per = a_per;
    iv = W'(a_iv); pv = W'(a_pv); td = TW'(a_td); tr = TW'(a_tr); th = TW'(a_th);
    tf = TW'(a_tf); tl = TW'(a_tl); rise_step = (W+8)'(a_rs); fall_step = (W+8)'(a_fs);
    periodic = a_per;
  endtask

  // Start a waveform and compare ncyc cycles against the model; optionally raise stop
  // after cycle stop_at. Inputs are scrambled and start is re-pulsed while busy.
  task automatic run_wave(input string tag, input int ncyc, input int stop_at);
    exp_t e;
    bit aborted;
    aborted = 1'b0;
    e = '0;
    start = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      if (aborted) begin
        e.out = 16'(m_iv); e.busy = 1'b0; e.done = 1'b0; e.phase = 3'd0;
      end else begin
        e = exp_at(i);
      end
      chk({tag, "_out"},   64'(out),   64'(e.out));
      chk({tag, "_busy"},  64'(busy),  64'(e.busy));
      chk({tag, "_done"},  64'(done),  64'(e.done));
      chk({tag, "_phase"}, 64'(phase), 64'(e.phase));
`ifdef TRAP_PULSE_GEN_PERIOD_COUNT_EN
      chk({tag, "_periods"}, 64'(periods), 64'(e.periods));
`endif
      if (i == stop_at) begin
        stop = 1'b1;
        aborted = 1'b1;
      end
      if (i == 1) begin
        iv = W'($urandom); pv = W'($urandom);
        td = TW'($urandom_range(0, 5)); tr = TW'($urandom_range(0, 5));
        th = TW'($urandom_range(0, 5)); tf = TW'($urandom_range(0, 5));
        tl = TW'($urandom_range(0, 5)); periodic = $urandom_range(0, 1);
        rise_step = (W+8)'($urandom); fall_step = (W+8)'($urandom);
      end
      start = (e.busy && i < ncyc) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  int os_ref [15] = '{100, 100, 350, 600, 850, 1100, 1100, 1100, 1100, 850, 600, 350, 100, 100, 100};

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_phase", 64'(phase), 64'(P_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // One shot, rising: fixed expected sequence.
    set_cfg(100, 1100, 2, 4, 3, 4, 0, 250 * 256, 250 * 256, 1'b0);
    start = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("os_out", 64'(out), 64'(os_ref[i-1]));
      chk("os_done", 64'(done), 64'(i == 14));
      chk("os_busy", 64'(busy), 64'(i <= 13));
      if (i == 3) pv = 16'd7;
    end

    // Periodic, three periods, then stop.
    set_cfg(100, 1100, 2, 4, 3, 4, 2, 250 * 256, 250 * 256, 1'b1);
    run_wave("per", 2 + 13 * 3 + 2, 2 + 13 * 3);

    // Inverted levels with saturation, fall ramping upward.
    set_cfg(1000, 0, 0, 3, 2, 3, 0, 500 * 256, 300 * 256, 1'b0);
    run_wave("inv", 11, 0);

    // Zero-length phases: HIGH only, then all-zero body.
    set_cfg(40, 900, 0, 0, 5, 0, 0, 256, 256, 1'b0);
    run_wave("zero_h", 8, 0);
    set_cfg(77, 900, 0, 0, 0, 0, 3, 256, 256, 1'b1);
    run_wave("zero_all", 4, 0);

    // Stop during HIGH: no done where the full waveform would have ended.
    set_cfg(100, 1100, 2, 4, 3, 4, 0, 250 * 256, 250 * 256, 1'b0);
    run_wave("stop_h", 16, 7);

    // start and stop together in IDLE.
    set_cfg(5, 6000, 1, 2, 2, 2, 0, 4000, 4000, 1'b0);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 64'(busy), 64'd0);
    chk("ss_phase", 64'(phase), 64'(P_IDLE));
    chk("ss_out", 64'(out), 64'd100);
    @(posedge clk); #1;
    chk("ss_busy2", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of RISE.
    set_cfg(100, 1100, 2, 4, 3, 4, 0, 250 * 256, 250 * 256, 1'b0);
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("ar_pre_phase", 64'(phase), 64'(P_RISE));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out", 64'(out), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_phase", 64'(phase), 64'(P_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("ar_idle_busy", 64'(busy), 64'd0);
      chk("ar_idle_out", 64'(out), 64'd0);
    end
    set_cfg(3000, 200, 1, 2, 1, 2, 1, 9000, 100000, 1'b0);
    run_wave("ar_restart", 9, 0);
    chk("ar_restart_phase", 64'(phase), 64'(P_IDLE));

    // Randomized waveforms against the model.
    for (int n = 0; n < 40; n++) begin
      int r_td, r_tr, r_th, r_tf, r_tl, body, ncyc;
      bit r_per;
      r_tr = $urandom_range(0, 4); r_th = $urandom_range(0, 4); r_tf = $urandom_range(0, 4);
      r_tl = $urandom_range(0, 3); r_td = $urandom_range(0, 3); r_per = 1'($urandom_range(0, 1));
      body = r_tr + r_th + r_tf;
      if (body == 0) r_td = 0;
      set_cfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), r_td, r_tr,
              r_th, r_tf, r_tl, longint'($urandom_range(0, 1 << $urandom_range(4, 23))),
              longint'($urandom_range(0, 1 << $urandom_range(4, 23))), r_per);
      if (body == 0) begin
        run_wave("rnd_deg", 4, 0);
      end else if (r_per) begin
        ncyc = r_td + 2 * (body + r_tl) + 3;
        run_wave("rnd_per", ncyc, ncyc - 2);
      end else begin
        run_wave("rnd_os", r_td + body + 3, 0);
      end
    end
    chk("end_delay_not_stuck", 64'(phase == P_DELAY), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
